// File: rtl/scpad_pkg.sv
// Scratchpad row geometry, beat derivation helpers and the row-entry record
// shared by the DRAM write path.
package scpad_pkg;

    localparam int SCPAD_LANES     = 32;
    localparam int SCPAD_LANE_BITS = 16;
    localparam int SCPAD_ROW_BITS  = SCPAD_LANES * SCPAD_LANE_BITS;
    localparam int DRAM_BEAT_BITS  = 64;
    localparam int DRAM_ADDR_WIDTH = 32;
    localparam int SCPAD_ID_W      = 8;
    localparam int ROW_NB_W        = $clog2(SCPAD_ROW_BITS / 8) + 1;

    function automatic int beat_bytes_f(input int beat_bits);
        return beat_bits / 8;
    endfunction

    function automatic int nbeats_f(input int row_bits, input int beat_bits);
        return row_bits / beat_bits;
    endfunction

    typedef struct packed {
        logic [SCPAD_ROW_BITS-1:0]  data;
        logic [DRAM_ADDR_WIDTH-1:0] addr;
        logic [ROW_NB_W-1:0]        bytes;
        logic [SCPAD_ID_W-1:0]      id;
    } row_entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } wr_state_e;

endpackage

// File: rtl/dram_write_beat_queue_if.sv
// Row-offer and DRAM-beat signals of the write beat queue; master is the
// producer/backend side, slave is the queue.
interface dram_write_beat_queue_if #(
    parameter int ROW_BITS  = scpad_pkg::SCPAD_ROW_BITS,
    parameter int BEAT_BITS = scpad_pkg::DRAM_BEAT_BITS,
    parameter int ADDR_W    = scpad_pkg::DRAM_ADDR_WIDTH,
    parameter int ID_W      = scpad_pkg::SCPAD_ID_W
);
    localparam int NB_W = $clog2(ROW_BITS / 8) + 1;
    localparam int BB_W = $clog2(BEAT_BITS / 8) + 1;

    logic                 row_valid;
    logic [ROW_BITS-1:0]  row_data;
    logic [ADDR_W-1:0]    row_addr;
    logic [NB_W-1:0]      row_bytes;
    logic [ID_W-1:0]      row_id;
    logic                 row_ready;

    logic                 beat_valid;
    logic [BEAT_BITS-1:0] beat_wdata;
    logic [ADDR_W-1:0]    beat_addr;
    logic [BB_W-1:0]      beat_bytes;
    logic [ID_W-1:0]      beat_id;
    logic                 beat_last;
    logic                 be_stall;

    logic                 busy;
    logic                 row_latched;

    modport master (
        output row_valid, row_data, row_addr, row_bytes, row_id, be_stall,
        input  row_ready, beat_valid, beat_wdata, beat_addr, beat_bytes,
               beat_id, beat_last, busy, row_latched
    );

    modport slave (
        input  row_valid, row_data, row_addr, row_bytes, row_id, be_stall,
        output row_ready, beat_valid, beat_wdata, beat_addr, beat_bytes,
               beat_id, beat_last, busy, row_latched
    );
endinterface

// File: rtl/dram_wr_row_fifo.sv
// Row-entry storage for the write beat queue; pointers carry one extra bit so
// full and empty are distinguishable when the slot indices match.
module dram_wr_row_fifo
    import scpad_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    push,
    input  logic                    pop,
    input  row_entry_t              wr_entry,
    output row_entry_t              head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);

    row_entry_t  mem [DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // Payload storage needs no reset; occupancy is owned by the pointers.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr[PW-1:0]] <= wr_entry;
    end

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
    assign head  = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/dram_write_beat_queue.sv
// Buffers scratchpad rows and slices the head row into DRAM write beats.
//   state   | meaning
//   ST_IDLE | no row being sliced; waits for a non-empty head with bytes > 0
//   ST_SEND | presenting beats of the head row, chaining into the next row
module dram_write_beat_queue
    import scpad_pkg::*;
#(
    parameter int ROW_BITS  = SCPAD_ROW_BITS,
    parameter int BEAT_BITS = DRAM_BEAT_BITS,
    parameter int DEPTH     = 2,
    parameter int ADDR_W    = DRAM_ADDR_WIDTH,
    parameter int ID_W      = SCPAD_ID_W
) (
    input logic                    CLK,
    input logic                    nRST,
    dram_write_beat_queue_if.slave bus
);
    localparam int BEAT_B  = beat_bytes_f(BEAT_BITS);
    localparam int N_BEATS = nbeats_f(ROW_BITS, BEAT_BITS);
    localparam int ROW_B   = ROW_BITS / 8;
    localparam int NB_W    = $clog2(ROW_B) + 1;
    localparam int BB_W    = $clog2(BEAT_B) + 1;
    localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int PW      = $clog2(DEPTH);

    wr_state_e        state, state_nxt;
    row_entry_t       wr_entry, head;
    logic             full, empty;
    logic [PW:0]      count;
    logic [CNT_W-1:0] cnt;
    logic [NB_W-1:0]  eff_bytes;
    logic             accept, transfer, last, zero_pop, pop, beat_valid;
    int               nbeats, rem, occ_nxt;

    assign wr_entry = '{data: bus.row_data, addr: bus.row_addr,
                        bytes: bus.row_bytes, id: bus.row_id};

    dram_wr_row_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK      (CLK),
        .nRST     (nRST),
        .push     (accept),
        .pop      (pop),
        .wr_entry (wr_entry),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    assign eff_bytes = (head.bytes > NB_W'(ROW_B)) ? NB_W'(ROW_B) : head.bytes;

    always_comb begin
        nbeats  = (int'(eff_bytes) + BEAT_B - 1) / BEAT_B;
        rem     = int'(eff_bytes) - int'(cnt) * BEAT_B;
        occ_nxt = int'(count) - int'(pop) + int'(accept);
    end

    assign accept   = bus.row_valid && !full;
    assign last     = (int'(cnt) == nbeats - 1);
    assign transfer = beat_valid && !bus.be_stall;
    // Zero-byte rows never present a beat; they are retired straight from the head.
    assign zero_pop = !empty && (eff_bytes == '0);
    assign pop      = (transfer && last) || zero_pop;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (!empty && (eff_bytes != '0)) state_nxt = ST_SEND;
            ST_SEND: if (pop && (occ_nxt == 0))       state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        beat_valid = (state == ST_SEND) && !empty && (eff_bytes != '0);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)         cnt <= '0;
        else if (transfer) cnt <= last ? '0 : cnt + CNT_W'(1);
    end

    assign bus.row_ready   = !full;
    assign bus.row_latched = accept;
    assign bus.beat_valid  = beat_valid;
    assign bus.beat_wdata  = beat_valid ? head.data[int'(cnt)*BEAT_BITS +: BEAT_BITS] : '0;
    assign bus.beat_addr   = beat_valid ? head.addr + ADDR_W'(int'(cnt) * BEAT_B) : '0;
    assign bus.beat_bytes  = beat_valid ? ((rem >= BEAT_B) ? BB_W'(BEAT_B) : BB_W'(rem)) : '0;
    assign bus.beat_id     = beat_valid ? head.id : ID_W'(0);
    assign bus.beat_last   = beat_valid && last;
    assign bus.busy        = (count != '0) || beat_valid;

endmodule

// File: doc/dram_write_beat_queue.md
DRAM_WRITE_BEAT_QUEUE -- requirements
Module: dram_write_beat_queue

Interface
REQ-001 SHALL have parameter ROW_BITS, default 512, meaning scratchpad row width (32 lanes x 16 b).
REQ-002 SHALL have parameter BEAT_BITS, default 64, meaning DRAM write beat width; ROW_BITS is an integer multiple of BEAT_BITS.
REQ-003 SHALL have parameter DEPTH, default 2, meaning number of buffered rows (power of 2, >=2).
REQ-004 SHALL have parameter ADDR_W, default DRAM_ADDR_WIDTH, meaning DRAM byte-address width.
REQ-005 SHALL have parameter ID_W, default 8, meaning request tag width.
REQ-006 SHALL have port CLK, input, 1, meaning the single clock; all state on rising edge.
REQ-007 SHALL have port nRST, input, 1, meaning reset, asynchronous and active-low.
REQ-008 SHALL have inputs row_valid (1), row_data (ROW_BITS), row_addr (ADDR_W), row_bytes (NB_W = clog2(ROW_BITS/8)+1) and row_id (ID_W), meaning an offered row write.
REQ-009 SHALL have output row_ready, 1, meaning a row is accepted this cycle when row_valid && row_ready.
REQ-010 SHALL have outputs beat_valid (1), beat_wdata (BEAT_BITS), beat_addr (ADDR_W), beat_bytes (clog2(BEAT_BITS/8)+1), beat_id (ID_W) and beat_last (1), meaning the DRAM write beat.
REQ-011 SHALL have input be_stall, 1, meaning the backend cannot take a beat this cycle.
REQ-012 SHALL have outputs busy (1) and row_latched (1), meaning queue non-empty, and a one-cycle accept pulse.

Function
REQ-013 SHALL define BEAT_BYTES=BEAT_BITS/8 and NBEATS=ROW_BITS/BEAT_BITS.
REQ-014 SHALL compute row_ready = !full from registered occupancy only, with no same-cycle pop bypass.
REQ-015 SHALL, on accept, write {data, addr, bytes, id} into the tail entry, advance the tail, and pulse row_latched for exactly that cycle.
REQ-016 SHALL drain the head entry into ceil(row_bytes/BEAT_BYTES) beats, in ascending order of beat index k.
REQ-017 SHALL drive beat k as: wdata = row_data[k*BEAT_BITS +: BEAT_BITS], addr = row_addr + k*BEAT_BYTES (mod 2^ADDR_W), bytes = min(BEAT_BYTES, row_bytes - k*BEAT_BYTES), id = row_id.
REQ-018 SHALL assert beat_last on the final beat of each row only.
REQ-019 SHALL transfer a beat when beat_valid && !be_stall, advancing the beat counter.
REQ-020 SHALL hold beat_valid and every beat_* output stable while be_stall=1.
REQ-021 SHALL run a two-state FSM:
  - IDLE -> SEND when the queue is non-empty and the head entry has row_bytes>0.
  - SEND -> IDLE on the beat_last transfer when the queue then becomes empty.
  - SEND stays in SEND, with the counter reset to 0, when another entry is present.
REQ-022 SHALL have a first-beat latency of one cycle: a row accepted at edge t into an empty queue has beat_valid=1 after edge t+1; back-to-back rows produce no bubble.
REQ-023 SHALL accept an entry with row_bytes=0 (row_latched pulses), produce no beats, and free it one cycle after it reaches the head.
REQ-024 SHALL treat row_bytes > ROW_BITS/8 as equal to ROW_BITS/8.
REQ-025 SHALL complete accept and beat_last pop in the same cycle correctly; occupancy is unchanged.
REQ-026 SHALL wrap head/tail pointers modulo DEPTH, using an extra pointer bit to distinguish full from empty.
REQ-027 SHALL drive busy = (occupancy != 0) || beat_valid.

Reset
REQ-028 SHALL, while nRST=0, clear pointers, occupancy, beat counter and FSM (IDLE) asynchronously.
REQ-029 SHALL hold row_ready=1, beat_valid=0, beat_last=0, row_latched=0, busy=0 and all beat_* data/addr/bytes/id=0 during reset.
REQ-030 SHALL discard in-flight rows when reset is asserted mid-row; no beat is issued after reset release until a new row is accepted.

Structure
REQ-031 SHALL place the row-entry struct (data, addr, bytes, id) and the BEAT_BYTES/NBEATS derivation in scpad_pkg; defaults derive from the scpad_pkg row geometry.
REQ-032 SHALL implement entry storage as sub-module dram_wr_row_fifo (DEPTH x entry, full/empty/count); beat sequencing stays in the top.

Verification
REQ-033 SHALL cover: one row, addr 0x1000, bytes 64, no stall -> 8 beats on consecutive cycles, addrs 0x1000..0x1038, each bytes=8, beat_last on the 8th only.
REQ-034 SHALL cover: row_bytes 20 -> 3 beats, bytes 8,8,4, last on the 3rd; no 4th beat.
REQ-035 SHALL cover: be_stall=1 for 5 cycles during beat 2 -> beat 2 payload unchanged throughout, then beat 3 follows with no gap.
REQ-036 SHALL cover: three rows offered back-to-back with DEPTH=2 and be_stall held -> row_ready=0 after 2 accepts; the 3rd accepts the cycle after first beat_last; ids emerge in order.
REQ-037 SHALL cover: row_bytes 0, then a row with bytes 8 -> exactly one beat, with the second row's id.
REQ-038 SHALL cover: nRST pulsed low mid-row at beat 4 -> outputs zero immediately, busy=0, no beats after release.
